// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Reads and reservations of a busy register stall until that register's write-back.
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  input  logic [NRD-1:0]      rd_addr_valid,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_data_ack,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                wr_data_valid,
  output logic                wr_ack,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                rsv_valid,
  output logic                rsv_ack,
  output logic [NREGS-1:0]    busy
);

  logic [XLEN-1:0]  regs [NREGS];
  logic             wr_acc;
  logic             rsv_acc;
  logic [NRD-1:0]   rd_acc;
  logic [XLEN-1:0]  rd_val [NRD];
  logic [NREGS-1:0] busy_next;

  // A channel whose ack is high this cycle cannot accept again until the next one.
  always_comb begin
    wr_acc  = wr_data_valid && !wr_ack;
    rsv_acc = rsv_valid && !rsv_ack &&
              (!busy[rsv_addr] || (wr_acc && (wr_addr == rsv_addr)));
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      logic          hit;
      a         = rd_addr[i*AW +: AW];
      hit       = wr_acc && (wr_addr == a) && (a != '0);
      rd_acc[i] = rd_addr_valid[i] && !rd_data_ack[i] && (!busy[a] || hit);
      rd_val[i] = hit ? wr_data : regs[a];
    end
  end

  // The reservation's set is applied after the write's clear so it wins.
  always_comb begin
    busy_next = busy;
    if (wr_acc)
      busy_next[wr_addr] = 1'b0;
    if (rsv_acc)
      busy_next[rsv_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= '0;
      busy        <= '0;
      wr_ack      <= 1'b0;
      rsv_ack     <= 1'b0;
      rd_data_ack <= '0;
      rd_data     <= '0;
    end else begin
      wr_ack      <= wr_acc;
      rsv_ack     <= rsv_acc;
      rd_data_ack <= rd_acc;
      busy        <= busy_next;
      for (int i = 0; i < NRD; i++)
        if (rd_acc[i])
          rd_data[i*XLEN +: XLEN] <= rd_val[i];
      if (wr_acc && (wr_addr != '0))
        regs[wr_addr] <= wr_data;
    end
  end

endmodule
